// File: rtl/dice_pkg.sv
`default_nettype none
//==============================================================================
// dice_pkg : shared types and constants for the dice roll arbiter
// Rev 1.0
//==============================================================================
package dice_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROLL   = 2'd1,
      ST_REPORT = 2'd2,
      ST_ERROR  = 2'd3
   } arb_state_t;

   localparam logic [2:0]  DICE_MIN  = 3'd1;
   localparam logic [2:0]  DICE_MAX  = 3'd6;

   // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic dice_legal(input logic [2:0] v);
      return (v >= DICE_MIN) && (v <= DICE_MAX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dice_lfsr.sv
`default_nettype none
//==============================================================================
// dice_lfsr : free-running 16-bit Galois LFSR, steps every cycle
// Rev 1.0
//==============================================================================
module dice_lfsr
   import dice_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        Clock,
   input  logic        nReset,
   output logic [15:0] lfsr_state
);

   // A nonzero seed keeps the sequence off the all-zero lock-up state
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         lfsr_state <= SEED;
      end else begin
         lfsr_state <= {1'b0, lfsr_state[15:1]} ^ (lfsr_state[0] ? LFSR_TAPS : 16'h0000);
      end
   end

endmodule
`default_nettype wire

// File: rtl/dice_roll_arbiter.sv
`default_nettype none
//==============================================================================
// dice_roll_arbiter : round-robin sharing of one dice engine between players
// Rev 1.0
//==============================================================================
module dice_roll_arbiter
   import dice_pkg::*;
#(
   parameter int          NUM_PLAYERS = 4,
   parameter int          MIN_ROLL    = 8,
   parameter int          MAX_ROLL    = 64,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                           Clock,
   input  logic                           nReset,
   input  logic [NUM_PLAYERS-1:0]         Req,
   input  logic [NUM_PLAYERS-1:0]         Hold,
   input  logic [2:0]                     DiceValue,
   output logic [1:0]                     Ran,
   output logic [NUM_PLAYERS-1:0]         Grant,
   output logic                           Busy,
   output logic                           ResultValid,
   output logic [2:0]                     Result,
   output logic [$clog2(NUM_PLAYERS)-1:0] ResultPlayer,
   output logic                           Error
);

   localparam int SEL_W = $clog2(NUM_PLAYERS);
   localparam int CNT_W = $clog2(MAX_ROLL + 1);
   localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_ROLL);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ROLL);

   arb_state_t       state, state_nxt;
   logic [SEL_W-1:0] sel, sel_nxt;
   logic [SEL_W-1:0] ptr, ptr_nxt;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_found;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       result_nxt;
   logic [SEL_W-1:0] player_nxt;
   logic [15:0]      lfsr_state;
   logic             lfsr_unused;

   dice_lfsr #(
      .SEED       (LFSR_SEED)
   ) u_lfsr (
      .Clock      (Clock),
      .nReset     (nReset),
      .lfsr_state (lfsr_state)
   );

   assign Ran         = lfsr_state[1:0];
   assign lfsr_unused = ^lfsr_state[15:2];

   // Search starts one past the last served player so service rotates
   always_comb begin
      logic [SEL_W-1:0] idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      idx        = '0;
      for (int i = 1; i <= NUM_PLAYERS; i++) begin
         idx = SEL_W'((int'(ptr) + i) % NUM_PLAYERS);
         if (!pick_found && Req[idx]) begin
            pick_found = 1'b1;
            pick_idx   = idx;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      sel_nxt    = sel;
      ptr_nxt    = ptr;
      result_nxt = Result;
      player_nxt = ResultPlayer;

      if (state != ST_ERROR && !dice_legal(DiceValue)) begin
         state_nxt = ST_ERROR;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  sel_nxt   = pick_idx;
                  cnt_nxt   = CNT_W'(1);
                  state_nxt = ST_ROLL;
               end
            end
            ST_ROLL: begin
               if (cnt != MAX_C) begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
               // A withdrawn request wins over a completed roll
               if (!Req[sel]) begin
                  ptr_nxt   = sel;
                  state_nxt = ST_IDLE;
               end else if ((cnt >= MIN_C && !Hold[sel]) || cnt == MAX_C) begin
                  result_nxt = DiceValue;
                  player_nxt = sel;
                  ptr_nxt    = sel;
                  state_nxt  = ST_REPORT;
               end
            end
            ST_REPORT: state_nxt = ST_IDLE;
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      Grant       = '0;
      Busy        = (state != ST_IDLE);
      ResultValid = (state == ST_REPORT);
      Error       = (state == ST_ERROR);
      if (state == ST_ROLL || state == ST_REPORT) begin
         Grant[sel] = 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         sel          <= '0;
         ptr          <= SEL_W'(NUM_PLAYERS - 1);
         Result       <= DICE_MIN;
         ResultPlayer <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         sel          <= sel_nxt;
         ptr          <= ptr_nxt;
         Result       <= result_nxt;
         ResultPlayer <= player_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dice_roll_arbiter.sv
`default_nettype none
//==============================================================================
// tb_dice_roll_arbiter : scoreboard bench for dice_roll_arbiter
// Rev 1.0
//==============================================================================
module tb_dice_roll_arbiter;

   localparam int          NP       = 4;
   localparam int          MIN_ROLL = 8;
   localparam int          MAX_ROLL = 64;
   localparam logic [15:0] SEED     = 16'hACE1;

   logic          Clock = 1'b0;
   logic          nReset;
   logic [NP-1:0] Req;
   logic [NP-1:0] Hold;
   logic [2:0]    DiceValue;
   logic [1:0]    Ran;
   logic [NP-1:0] Grant;
   logic          Busy;
   logic          ResultValid;
   logic [2:0]    Result;
   logic [1:0]    ResultPlayer;
   logic          Error;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         player;
      logic [2:0] value;
   } exp_t;
   exp_t sb[$];

   always #5 Clock = ~Clock;

   dice_roll_arbiter #(
      .NUM_PLAYERS (NP),
      .MIN_ROLL    (MIN_ROLL),
      .MAX_ROLL    (MAX_ROLL),
      .LFSR_SEED   (SEED)
   ) dut (
      .Clock        (Clock),
      .nReset       (nReset),
      .Req          (Req),
      .Hold         (Hold),
      .DiceValue    (DiceValue),
      .Ran          (Ran),
      .Grant        (Grant),
      .Busy         (Busy),
      .ResultValid  (ResultValid),
      .Result       (Result),
      .ResultPlayer (ResultPlayer),
      .Error        (Error)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] galois_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   task automatic step();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic roll_die();
      DiceValue = 3'($urandom_range(1, 6));
   endtask

   task automatic do_reset();
      nReset    = 1'b0;
      Req       = '0;
      Hold      = '0;
      DiceValue = 3'd1;
      sb.delete();
      repeat (2) @(negedge Clock);
      nReset = 1'b1;
   endtask

   // Called at an IDLE negedge with Req already set; returns at the IDLE negedge after REPORT
   task automatic roll_and_check(input int exp_player, input logic [NP-1:0] hold_mask, input int exp_lat);
      logic [NP-1:0] oh;
      bit            bad;
      bit            seen;
      bit            pushed;
      int            lat;
      exp_t          e;
      oh = '0;
      oh[exp_player] = 1'b1;
      Hold = hold_mask;
      roll_die();
      step();
      checks++;
      if (Grant !== oh || Busy !== 1'b1)
         begin errors++; $display("FAIL grant_p%0d: got grant=%b busy=%b, expected grant=%b busy=1", exp_player, Grant, Busy, oh); end
      bad = 0; seen = 0; pushed = 0; lat = 0;
      for (int c = 1; c <= MAX_ROLL + 2; c++) begin
         roll_die();
         if (!pushed && ((c >= MIN_ROLL && !hold_mask[exp_player]) || c == MAX_ROLL)) begin
            sb.push_back('{exp_player, DiceValue});
            pushed = 1;
         end
         step();
         if (ResultValid === 1'b1) begin
            seen = 1;
            lat  = c;
            break;
         end
         if (Grant !== oh) bad = 1;
      end
      checks++;
      if (bad)
         begin errors++; $display("FAIL grant_held_p%0d: grant dropped or changed during roll, expected %b", exp_player, oh); end
      // Grant cycle counts as cycle 1, so an edge distance of MIN_ROLL lands ResultValid on cycle MIN_ROLL+1
      checks++;
      if (!seen || lat != exp_lat)
         begin errors++; $display("FAIL latency_p%0d: got %0d edges (seen=%0d), expected %0d", exp_player, lat, seen, exp_lat); end
      if (seen) begin
         checks++;
         if (sb.size() == 0) begin
            errors++; $display("FAIL scoreboard_p%0d: result with no expected entry, got value=%0d player=%0d", exp_player, Result, ResultPlayer);
         end else begin
            e = sb.pop_front();
            if (Result !== e.value || ResultPlayer !== 2'(e.player))
               begin errors++; $display("FAIL result_p%0d: got value=%0d player=%0d, expected value=%0d player=%0d", exp_player, Result, ResultPlayer, e.value, e.player); end
         end
         checks++;
         if (Result < 3'd1 || Result > 3'd6)
            begin errors++; $display("FAIL result_range_p%0d: got %0d, expected 1..6", exp_player, Result); end
         checks++;
         if (Grant !== oh)
            begin errors++; $display("FAIL report_grant_p%0d: got %b, expected %b", exp_player, Grant, oh); end
      end
      Hold = '0;
      roll_die();
      step();
      checks++;
      if (ResultValid !== 1'b0 || Grant !== '0 || Busy !== 1'b0)
         begin errors++; $display("FAIL post_report_p%0d: got rv=%b grant=%b busy=%b, expected 0/0000/0", exp_player, ResultValid, Grant, Busy); end
   endtask

   task automatic test_reset();
      logic [15:0] exp;
      do_reset();
      checks++;
      if (Grant !== 4'b0000 || Busy !== 1'b0 || ResultValid !== 1'b0)
         begin errors++; $display("FAIL reset_ctrl: got grant=%b busy=%b rv=%b, expected 0000/0/0", Grant, Busy, ResultValid); end
      checks++;
      if (Result !== 3'd1 || ResultPlayer !== 2'd0 || Error !== 1'b0)
         begin errors++; $display("FAIL reset_data: got result=%0d player=%0d error=%b, expected 1/0/0", Result, ResultPlayer, Error); end
      exp = SEED;
      checks++;
      if (Ran !== exp[1:0])
         begin errors++; $display("FAIL reset_ran: got %b, expected %b", Ran, exp[1:0]); end
      for (int i = 0; i < 16; i++) begin
         roll_die();
         step();
         exp = galois_next(exp);
         checks++;
         if (Ran !== exp[1:0])
            begin errors++; $display("FAIL lfsr_step%0d: got %b, expected %b", i, Ran, exp[1:0]); end
      end
   endtask

   task automatic test_single_player();
      do_reset();
      Req = 4'b0100;
      roll_and_check(2, 4'b1011, MIN_ROLL);
      Req = '0;
      roll_die();
      step();
   endtask

   task automatic test_round_robin();
      do_reset();
      Req = 4'b1111;
      for (int i = 0; i < 8; i++) roll_and_check(i % NP, 4'b0000, MIN_ROLL);
      Req = '0;
      roll_die();
      step();
   endtask

   task automatic test_hold_max();
      do_reset();
      Req = 4'b0001;
      roll_and_check(0, 4'b0001, MAX_ROLL);
      Req = '0;
      roll_die();
      step();
   endtask

   task automatic test_abort();
      bit bad;
      do_reset();
      Req = 4'b1111;
      roll_die();
      step();
      checks++;
      if (Grant !== 4'b0001)
         begin errors++; $display("FAIL abort_grant: got %b, expected 0001", Grant); end
      bad = 0;
      for (int c = 2; c <= 5; c++) begin
         roll_die();
         step();
         if (ResultValid !== 1'b0 || Grant !== 4'b0001) bad = 1;
      end
      checks++;
      if (bad)
         begin errors++; $display("FAIL abort_pre: grant/rv wrong before drop, expected 0001/0"); end
      Req = 4'b1110;
      roll_die();
      step();
      checks++;
      if (Grant !== 4'b0000 || Busy !== 1'b0 || ResultValid !== 1'b0)
         begin errors++; $display("FAIL abort_idle: got grant=%b busy=%b rv=%b, expected 0000/0/0", Grant, Busy, ResultValid); end
      checks++;
      if (Result !== 3'd1 || ResultPlayer !== 2'd0)
         begin errors++; $display("FAIL abort_result: got result=%0d player=%0d, expected 1/0", Result, ResultPlayer); end
      roll_and_check(1, 4'b0000, MIN_ROLL);
      Req = '0;
      roll_die();
      step();
   endtask

   task automatic test_error();
      bit bad;
      do_reset();
      Req = 4'b0001;
      roll_die();
      step();
      repeat (3) begin roll_die(); step(); end
      DiceValue = 3'd7;
      step();
      checks++;
      if (Error !== 1'b1 || Grant !== 4'b0000 || Busy !== 1'b1 || ResultValid !== 1'b0)
         begin errors++; $display("FAIL error_enter: got err=%b grant=%b busy=%b rv=%b, expected 1/0000/1/0", Error, Grant, Busy, ResultValid); end
      Req = 4'b1111;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         roll_die();
         step();
         if (Error !== 1'b1 || Grant !== 4'b0000 || ResultValid !== 1'b0) bad = 1;
      end
      checks++;
      if (bad)
         begin errors++; $display("FAIL error_sticky: error cleared or grant/rv asserted, expected err=1 grant=0000 rv=0"); end
      do_reset();
      checks++;
      if (Error !== 1'b0 || Busy !== 1'b0)
         begin errors++; $display("FAIL error_clear: got err=%b busy=%b, expected 0/0", Error, Busy); end
   endtask

   task automatic test_reset_mid_roll();
      logic [15:0] exp;
      do_reset();
      Req = 4'b0010;
      roll_die();
      step();
      repeat (4) begin roll_die(); step(); end
      checks++;
      if (Busy !== 1'b1 || Grant !== 4'b0010)
         begin errors++; $display("FAIL midroll_pre: got busy=%b grant=%b, expected 1/0010", Busy, Grant); end
      #2 nReset = 1'b0;
      #1;
      checks++;
      if (Grant !== 4'b0000 || Busy !== 1'b0 || ResultValid !== 1'b0 || Error !== 1'b0)
         begin errors++; $display("FAIL midroll_ctrl: got grant=%b busy=%b rv=%b err=%b, expected 0000/0/0/0", Grant, Busy, ResultValid, Error); end
      checks++;
      if (Result !== 3'd1 || ResultPlayer !== 2'd0)
         begin errors++; $display("FAIL midroll_data: got result=%0d player=%0d, expected 1/0", Result, ResultPlayer); end
      exp = SEED;
      checks++;
      if (Ran !== exp[1:0])
         begin errors++; $display("FAIL midroll_ran: got %b, expected %b", Ran, exp[1:0]); end
      Req = '0;
      @(negedge Clock);
      nReset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         roll_die();
         step();
         exp = galois_next(exp);
         checks++;
         if (Ran !== exp[1:0] || ResultValid !== 1'b0)
            begin errors++; $display("FAIL midroll_lfsr%0d: got ran=%b rv=%b, expected ran=%b rv=0", i, Ran, ResultValid, exp[1:0]); end
      end
   endtask

   initial begin
      test_reset();
      test_single_player();
      test_round_robin();
      test_hold_max();
      test_abort();
      test_error();
      test_reset_mid_roll();
      checks++;
      if (sb.size() != 0)
         begin errors++; $display("FAIL sb_leftover: got %0d pending entries, expected 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
